i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
Stereo I2S transmitter that sits after the digital effects core. It turns the core's parallel left/right output samples into a serial I2S stream for the codec DAC.
- Samples arrive with a one-cycle VALID strobe and are double-buffered.
- Each frame is serialized MSB-first, Philips I2S format (data delayed one BCLK after each LRCLK edge).
- BCLK and LRCLK are generated from clk.

Parameters:
SAMPLE_W, 16, sample width in bits
SLOT_W, 32, BCLK periods per channel slot; must be ≥ SAMPLE_W+1
BCLK_DIV, 4, clk cycles per BCLK period; even, ≥ 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
VALID  in  1  one-cycle strobe: left_in/right_in hold a new sample pair
left_in  in  SAMPLE_W  left sample, two's complement
right_in  in  SAMPLE_W  right sample, two's complement
BCLK  out  1  I2S bit clock
LRCLK  out  1  word select; 0 = left slot, 1 = right slot
SDOUT  out  1  I2S serial data
frame_start  out  1  one-cycle pulse when a sample pair is loaded for transmission
underrun  out  1  one-cycle pulse: frame loaded with no new VALID since the previous load
overrun  out  1  one-cycle pulse: VALID overwrote an unconsumed hold pair

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: div_cnt, bit_cnt, hold and active registers clear to 0; hold_full clears to 0. BCLK, LRCLK, SDOUT, frame_start, underrun and overrun all read 0 in the cycle after rst is sampled high. Reset mid-frame aborts the frame immediately; there is no completion.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - BCLK register is 1 while div_cnt ≥ BCLK_DIV/2.
  - Falling-edge event "fall" is the cycle where div_cnt == BCLK_DIV-1. The next cycle BCLK drops and bit_cnt advances modulo 2*SLOT_W.
- LRCLK is registered: 0 for bit_cnt 0..SLOT_W-1, 1 otherwise. It changes on the same cycle as the BCLK fall.
- SDOUT is registered and updates only on fall edges:
  - left slot, bit_cnt b in 1..SAMPLE_W: active_l[SAMPLE_W-b];
  - right slot, b in SLOT_W+1..SLOT_W+SAMPLE_W: active_r[SLOT_W+SAMPLE_W-b];
  - all other slot positions: 0.
- Hold buffer:
  - On VALID: hold_l/hold_r ← inputs and hold_full ← 1.
  - If hold_full was already 1 and no frame load occurs that cycle, overrun pulses. The last write wins.
- Frame load happens on the fall that wraps bit_cnt to 0, except the first frame after reset:
  - active ← hold, or ← the inputs directly if VALID is high the same cycle (bypass; this counts as new data).
  - hold_full ← 0 and frame_start pulses.
  - If neither hold_full nor VALID is set, active keeps its previous value (repeat sample) and underrun pulses.
- Latency: a sample pair accepted before a frame load starts on SDOUT one BCLK after that load (slot bit 1). The full pair completes within 2 frames.
- Frame length is 2*SLOT_W*BCLK_DIV clk cycles. There is no handshake back-pressure; the upstream core runs at the frame rate.

Decomposition:
- Package i2s_pkg holds:
  - default SAMPLE_W / SLOT_W / BCLK_DIV localparams;
  - typedef stereo_sample_t (struct of left and right, each logic [SAMPLE_W-1:0]);
  - a function computing frame length in clk cycles.
- Sub-module i2s_clk_gen contains div_cnt and bit_cnt and outputs BCLK, LRCLK, fall, frame_wrap and bit_cnt. i2s_dac_tx instantiates it and holds the buffers and serializer.

Test Plan:
All scenarios use default parameters: frame = 256 clk.
- Reset hold 10 cycles, then release: all outputs 0 during reset; BCLK period 4 clk (2 low, 2 high); LRCLK toggles every 128 clk; SDOUT stays 0 in frame 0.
- VALID with left=16'hA5C3, right=16'h8001 before a load: next frame SDOUT left bits 1..16 = 1010010111000011 and right bits 33..48 = 1000000000000001; all other slot positions 0; frame_start single pulse.
- No VALID across a load after left=16'h1234: underrun pulses once; 16'h1234 is retransmitted; frame_start still pulses.
- Two VALIDs in one frame (16'h1111 then 16'h5678 left): overrun pulses on the second VALID; next frame transmits 16'h5678.
- VALID coincident with a load cycle carrying 16'h7FFF: transmitted in that frame; no underrun, no overrun.
- rst asserted at bit_cnt 40: next cycle all outputs 0; after release, timing restarts from bit_cnt 0; the old hold data is not transmitted.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults, stereo sample type and frame-length helper for the I2S DAC transmitter
package i2s_pkg;
  localparam int I2S_SAMPLE_W = 16;
  localparam int I2S_SLOT_W = 32;
  localparam int I2S_BCLK_DIV = 4;
  typedef struct packed {
    logic [I2S_SAMPLE_W-1:0] left;
    logic [I2S_SAMPLE_W-1:0] right;
  } stereo_sample_t;
  function automatic int frame_clks(int slot_w, int bclk_div);
    return 2 * slot_w * bclk_div;
  endfunction
endpackage

// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if: sample input strobe/data and serial I2S outputs with status pulses
interface i2s_dac_tx_if
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W
);
  logic                VALID;
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                BCLK;
  logic                LRCLK;
  logic                SDOUT;
  logic                frame_start;
  logic                underrun;
  logic                overrun;
  modport master (
    output VALID, left_in, right_in,
    input  BCLK, LRCLK, SDOUT, frame_start, underrun, overrun
  );
  modport slave (
    input  VALID, left_in, right_in,
    output BCLK, LRCLK, SDOUT, frame_start, underrun, overrun
  );
endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk into BCLK, tracks the slot bit position and derives LRCLK
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV,
  localparam int DW = $clog2(BCLK_DIV),
  localparam int BW = $clog2(2 * SLOT_W)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bclk,
  output logic          lrclk,
  output logic          fall,
  output logic          frame_wrap,
  output logic [BW-1:0] bit_cnt
);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d;
  always_comb begin
    fall = div_cnt_q == DW'(BCLK_DIV - 1);
    frame_wrap = fall && bit_cnt_q == BW'(2 * SLOT_W - 1);
    div_cnt_d = fall ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d = frame_wrap ? '0 : bit_cnt_q + BW'(fall);
    bclk_d = div_cnt_d >= DW'(BCLK_DIV / 2);
    lrclk_d = bit_cnt_d >= BW'(SLOT_W);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end
  assign bclk = bclk_q;
  assign lrclk = lrclk_q;
  assign bit_cnt = bit_cnt_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: double-buffered stereo sample capture and Philips I2S MSB-first serializer
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input logic clk,
  input logic rst,
  i2s_dac_tx_if.slave bus
);
  localparam int BW = $clog2(2 * SLOT_W);
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;
  logic bclk, lrclk, fall, frame_wrap;
  logic [BW-1:0] bit_cnt, nb, slot_pos;
  logic [SAMPLE_W-1:0] word, sh;
  logic in_word;
  pair_t in_pair, hold_q, hold_d, active_q, active_d;
  logic hold_full_q, hold_full_d, sdout_q, sdout_d;
  logic fs_q, fs_d, ur_q, ur_d, or_q, or_d;
  i2s_clk_gen #(
    .SLOT_W(SLOT_W),
    .BCLK_DIV(BCLK_DIV)
  ) u_clk_gen (
    .clk(clk),
    .rst(rst),
    .bclk(bclk),
    .lrclk(lrclk),
    .fall(fall),
    .frame_wrap(frame_wrap),
    .bit_cnt(bit_cnt)
  );
  always_comb begin
    in_pair = {bus.left_in, bus.right_in};
    hold_d = bus.VALID ? in_pair : hold_q;
    hold_full_d = !frame_wrap && (hold_full_q || bus.VALID);
    active_d = !frame_wrap ? active_q : bus.VALID ? in_pair : hold_full_q ? hold_q : active_q;
    fs_d = frame_wrap;
    ur_d = frame_wrap && !hold_full_q && !bus.VALID;
    or_d = bus.VALID && hold_full_q && !frame_wrap;
    // SDOUT shows the bit of the position bit_cnt is about to enter; the wrap position is always 0
    nb = frame_wrap ? '0 : bit_cnt + BW'(1);
    slot_pos = nb >= BW'(SLOT_W) ? nb - BW'(SLOT_W) : nb;
    word = nb >= BW'(SLOT_W) ? active_q.right : active_q.left;
    in_word = slot_pos != '0 && slot_pos <= BW'(SAMPLE_W);
    sh = word << (slot_pos - BW'(1));
    sdout_d = fall ? in_word && sh[SAMPLE_W-1] : sdout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      active_q <= '0;
      hold_full_q <= 1'b0;
      sdout_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      or_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      active_q <= active_d;
      hold_full_q <= hold_full_d;
      sdout_q <= sdout_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
      or_q <= or_d;
    end
  end
  assign bus.BCLK = bclk;
  assign bus.LRCLK = lrclk;
  assign bus.SDOUT = sdout_q;
  assign bus.frame_start = fs_q;
  assign bus.underrun = ur_q;
  assign bus.overrun = or_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: scenario tasks checking every cycle against a frame-level reference model
module tb_i2s_dac_tx;
  import i2s_pkg::*;
  localparam int W = I2S_SAMPLE_W;
  localparam int SL = I2S_SLOT_W;
  localparam int DV = I2S_BCLK_DIV;
  localparam int F = frame_clks(SL, DV);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2s_dac_tx_if #(.SAMPLE_W(W)) io ();
  i2s_dac_tx #(.SAMPLE_W(W), .SLOT_W(SL), .BCLK_DIV(DV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(io)
  );
  int checks = 0;
  int fails = 0;
  int n;
  stereo_sample_t cur, pend_s;
  bit pend, e_fs, e_ur, e_or;
  logic [5:0] obs;
  assign obs = {io.BCLK, io.LRCLK, io.SDOUT, io.frame_start, io.underrun, io.overrun};
  task automatic model_reset();
    n = 0;
    cur = '0;
    pend = 0;
    e_fs = 0;
    e_ur = 0;
    e_or = 0;
  endtask
  function automatic logic [5:0] exp_vec();
    int b;
    logic [2*SL-1:0] v, s;
    b = (n / DV) % (2 * SL);
    v = {1'b0, cur.left, {(SL-W-1){1'b0}}, 1'b0, cur.right, {(SL-W-1){1'b0}}};
    s = v << b;
    return {(n % DV) >= DV / 2, b >= SL, s[2*SL-1], e_fs, e_ur, e_or};
  endfunction
  task automatic step(input bit v, input logic [W-1:0] l, input logic [W-1:0] r);
    bit load;
    load = (n % F) == F - 1;
    io.VALID = v;
    io.left_in = v ? l : W'($urandom);
    io.right_in = v ? r : W'($urandom);
    e_fs = load;
    e_ur = load && !pend && !v;
    e_or = v && pend && !load;
    if (load) begin
      if (v) cur = '{left: l, right: r};
      else if (pend) cur = pend_s;
      pend = 0;
    end else if (v) begin
      pend = 1;
      pend_s = '{left: l, right: r};
    end
    @(posedge clk);
    @(negedge clk);
    n++;
    io.VALID = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    io.VALID = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 6'b0) begin
        fails++;
        $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
      end
    end
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(0, '0, '0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL reset_release n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_sample();
    bit sent = 0, v;
    for (int i = 0; i < 3 * F; i++) begin
      v = !sent && n % F == 100;
      if (v) sent = 1;
      step(v, 16'hA5C3, 16'h8001);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL sample n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_underrun();
    bit sent = 0, v;
    for (int i = 0; i < 3 * F; i++) begin
      v = !sent && n % F == 50;
      if (v) sent = 1;
      step(v, 16'h1234, 16'h0F0F);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL underrun n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_overrun();
    bit s1 = 0, s2 = 0, v;
    for (int i = 0; i < 3 * F; i++) begin
      v = (!s1 && n % F == 30) || (s1 && !s2 && n % F == 90);
      step(v, s1 ? 16'h5678 : 16'h1111, s1 ? 16'hBBBB : 16'hAAAA);
      if (v && s1) s2 = 1;
      if (v) s1 = 1;
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL overrun n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_coincident();
    bit sent = 0, v;
    for (int i = 0; i < 3 * F; i++) begin
      v = !sent && n % F == F - 1;
      if (v) sent = 1;
      step(v, 16'h7FFF, 16'h0042);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL coincident n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_reset_mid();
    bit sent = 0, v;
    for (int i = 0; i < 2 * F; i++) begin
      v = !sent && n % F == 10;
      if (v) sent = 1;
      step(v, 16'hABCD, 16'h1357);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL pre_reset n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
      if (sent && (n / DV) % (2 * SL) == 40) break;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset got=%b exp=%b", obs, 6'b0);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * F; i++) begin
      step(0, '0, '0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL post_reset n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  task automatic test_random();
    bit v;
    for (int i = 0; i < 16 * F; i++) begin
      v = $urandom_range(0, 199) == 0 || (n % F == F - 1 && $urandom_range(0, 3) == 0);
      step(v, W'($urandom), W'($urandom));
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random n=%0d got=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask
  initial begin
    io.VALID = 1'b0;
    io.left_in = '0;
    io.right_in = '0;
    test_reset();
    test_sample();
    test_underrun();
    test_overrun();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
